// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, funct codes,
// FSM states, ALU operations, datapath select values and instruction classes.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_XOR = 3'd2;
  localparam logic [2:0] ALU_SLT = 3'd3;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_JUMP   = 2'b01;
  localparam logic [1:0] PC_RS     = 2'b10;
  localparam logic [1:0] PC_BRANCH = 2'b11;

  localparam logic [1:0] RD_RT  = 2'b00;
  localparam logic [1:0] RD_RD  = 2'b01;
  localparam logic [1:0] RD_R31 = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

  typedef enum logic [3:0] {
    CLS_ILLEGAL = 4'd0,
    CLS_J       = 4'd1,
    CLS_JAL     = 4'd2,
    CLS_JR      = 4'd3,
    CLS_LW      = 4'd4,
    CLS_SW      = 4'd5,
    CLS_BNE     = 4'd6,
    CLS_ADDI    = 4'd7,
    CLS_XORI    = 4'd8,
    CLS_RTYPE   = 4'd9
  } instr_cls_e;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control bus between the multicycle control unit (master) and the datapath
// (slave): instruction fields and status in, selects and enables out.
interface multicycle_control_fsm_if #(
  parameter int OP_W     = 6,
  parameter int FUNCT_W  = 6,
  parameter int ALU_OP_W = 3
);
  logic [OP_W-1:0]     opcode;
  logic [FUNCT_W-1:0]  funct;
  logic                zero_flag;
  logic                mem_ready;
  logic                pc_we;
  logic [1:0]          pc_src;
  logic                ir_we;
  logic                mem_addr_sel;
  logic                mem_re;
  logic                mem_we;
  logic                reg_we;
  logic [1:0]          reg_dst;
  logic [1:0]          wb_sel;
  logic                alu_src_b;
  logic [ALU_OP_W-1:0] alu_op;
  logic                illegal;
  logic                instr_done;
  logic [2:0]          state;

  modport master (
    input  opcode, funct, zero_flag, mem_ready,
    output pc_we, pc_src, ir_we, mem_addr_sel, mem_re, mem_we, reg_we,
           reg_dst, wb_sel, alu_src_b, alu_op, illegal, instr_done, state
  );

  modport slave (
    output opcode, funct, zero_flag, mem_ready,
    input  pc_we, pc_src, ir_we, mem_addr_sel, mem_re, mem_we, reg_we,
           reg_dst, wb_sel, alu_src_b, alu_op, illegal, instr_done, state
  );
endinterface

// File: rtl/multicycle_control_fsm_decode.sv
// Combinational instruction decoder: maps opcode/funct to an instruction class,
// the ALU operation and B-operand select used in EXEC, and an illegal flag.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OP_W     = 6,
  parameter int FUNCT_W  = 6,
  parameter int ALU_OP_W = 3
) (
  input  logic [OP_W-1:0]     opcode,
  input  logic [FUNCT_W-1:0]  funct,
  output instr_cls_e          cls,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_src_b,
  output logic                illegal
);

  always_comb begin
    cls       = CLS_ILLEGAL;
    alu_op    = ALU_OP_W'(ALU_ADD);
    alu_src_b = 1'b0;
    case (opcode)
      OP_W'(OP_J):    cls = CLS_J;
      OP_W'(OP_JAL):  cls = CLS_JAL;
      OP_W'(OP_LW): begin
        cls       = CLS_LW;
        alu_src_b = 1'b1;
      end
      OP_W'(OP_SW): begin
        cls       = CLS_SW;
        alu_src_b = 1'b1;
      end
      OP_W'(OP_ADDI): begin
        cls       = CLS_ADDI;
        alu_src_b = 1'b1;
      end
      OP_W'(OP_XORI): begin
        cls       = CLS_XORI;
        alu_op    = ALU_OP_W'(ALU_XOR);
        alu_src_b = 1'b1;
      end
      OP_W'(OP_BNE): begin
        cls    = CLS_BNE;
        alu_op = ALU_OP_W'(ALU_SUB);
      end
      OP_W'(OP_RTYPE): begin
        // Unknown funct codes under opcode 0 leave the class as illegal.
        case (funct)
          FUNCT_W'(FN_JR):  cls = CLS_JR;
          FUNCT_W'(FN_ADD): cls = CLS_RTYPE;
          FUNCT_W'(FN_SUB): begin
            cls    = CLS_RTYPE;
            alu_op = ALU_OP_W'(ALU_SUB);
          end
          FUNCT_W'(FN_SLT): begin
            cls    = CLS_RTYPE;
            alu_op = ALU_OP_W'(ALU_SLT);
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign illegal = (cls == CLS_ILLEGAL);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB control unit with a mem_ready handshake.
// Define MULTICYCLE_CTRL_PERF_EN to add cycle_count/instr_count outputs.
module multicycle_control_fsm
  import ctrl_pkg::*;
#(
`ifdef MULTICYCLE_CTRL_PERF_EN
  parameter int CNT_W    = 32,
`endif
  parameter int OP_W     = 6,
  parameter int FUNCT_W  = 6,
  parameter int ALU_OP_W = 3
) (
  input logic                     clk,
  input logic                     reset,
  multicycle_control_fsm_if.master ctrl
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]        cycle_count,
  output logic [CNT_W-1:0]        instr_count
`endif
);

  state_e              state_q, state_d;
  instr_cls_e          cls;
  logic [ALU_OP_W-1:0] dec_alu_op;
  logic                dec_alu_src_b;
  logic                dec_illegal;

  logic                pc_we, ir_we, mem_addr_sel, mem_re, mem_we, reg_we;
  logic [1:0]          pc_src, reg_dst, wb_sel;
  logic                alu_src_b, illegal, instr_done;
  logic [ALU_OP_W-1:0] alu_op;

  ctrl_decode #(
    .OP_W     (OP_W),
    .FUNCT_W  (FUNCT_W),
    .ALU_OP_W (ALU_OP_W)
  ) u_decode (
    .opcode    (ctrl.opcode),
    .funct     (ctrl.funct),
    .cls       (cls),
    .alu_op    (dec_alu_op),
    .alu_src_b (dec_alu_src_b),
    .illegal   (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (ctrl.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (dec_illegal || cls == CLS_J || cls == CLS_JAL || cls == CLS_JR)
          state_d = S_FETCH;
        else
          state_d = S_EXEC;
      end
      S_EXEC: begin
        if (cls == CLS_BNE)                      state_d = S_FETCH;
        else if (cls == CLS_LW || cls == CLS_SW) state_d = S_MEM;
        else                                     state_d = S_WB;
      end
      S_MEM: begin
        if (ctrl.mem_ready) state_d = (cls == CLS_LW) ? S_WB : S_FETCH;
      end
      S_WB:    state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_we        = 1'b0;
    pc_src       = PC_PLUS4;
    ir_we        = 1'b0;
    mem_addr_sel = 1'b0;
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    reg_we       = 1'b0;
    reg_dst      = RD_RT;
    wb_sel       = WB_ALU;
    alu_src_b    = 1'b0;
    alu_op       = '0;
    illegal      = 1'b0;
    instr_done   = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_re = 1'b1;
        if (ctrl.mem_ready) begin
          ir_we = 1'b1;
          pc_we = 1'b1;
        end
      end
      S_DECODE: begin
        case (cls)
          CLS_J: begin
            pc_we      = 1'b1;
            pc_src     = PC_JUMP;
            instr_done = 1'b1;
          end
          CLS_JAL: begin
            pc_we      = 1'b1;
            pc_src     = PC_JUMP;
            reg_we     = 1'b1;
            reg_dst    = RD_R31;
            wb_sel     = WB_PC;
            instr_done = 1'b1;
          end
          CLS_JR: begin
            pc_we      = 1'b1;
            pc_src     = PC_RS;
            instr_done = 1'b1;
          end
          CLS_ILLEGAL: begin
            illegal    = 1'b1;
            instr_done = 1'b1;
          end
          default: ;
        endcase
      end
      S_EXEC: begin
        alu_op    = dec_alu_op;
        alu_src_b = dec_alu_src_b;
        if (cls == CLS_BNE) begin
          pc_we      = ~ctrl.zero_flag;
          pc_src     = PC_BRANCH;
          instr_done = 1'b1;
        end
      end
      S_MEM: begin
        // ALU result stays the memory address, so its controls are held here.
        alu_op       = dec_alu_op;
        alu_src_b    = dec_alu_src_b;
        mem_addr_sel = 1'b1;
        mem_re       = (cls == CLS_LW);
        mem_we       = (cls == CLS_SW);
        instr_done   = (cls == CLS_SW) && ctrl.mem_ready;
      end
      S_WB: begin
        alu_op     = dec_alu_op;
        alu_src_b  = dec_alu_src_b;
        reg_we     = 1'b1;
        instr_done = 1'b1;
        if (cls == CLS_LW)         wb_sel  = WB_MEM;
        else if (cls == CLS_RTYPE) reg_dst = RD_RD;
      end
      default: ;
    endcase
  end

  // Reset overrides every output so an aborted instruction commits nothing.
  assign ctrl.pc_we        = pc_we & ~reset;
  assign ctrl.pc_src       = reset ? 2'b00 : pc_src;
  assign ctrl.ir_we        = ir_we & ~reset;
  assign ctrl.mem_addr_sel = mem_addr_sel & ~reset;
  assign ctrl.mem_re       = mem_re & ~reset;
  assign ctrl.mem_we       = mem_we & ~reset;
  assign ctrl.reg_we       = reg_we & ~reset;
  assign ctrl.reg_dst      = reset ? 2'b00 : reg_dst;
  assign ctrl.wb_sel       = reset ? 2'b00 : wb_sel;
  assign ctrl.alu_src_b    = alu_src_b & ~reset;
  assign ctrl.alu_op       = reset ? '0 : alu_op;
  assign ctrl.illegal      = illegal & ~reset;
  assign ctrl.instr_done   = instr_done & ~reset;
  assign ctrl.state        = reset ? 3'd0 : state_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;

  always_comb begin
    cycle_count_d = cycle_count_q + CNT_W'(1);
    instr_count_d = instr_count_q + CNT_W'(instr_done);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count_q <= '0;
      instr_count_q <= '0;
    end else begin
      cycle_count_q <= cycle_count_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign cycle_count = cycle_count_q;
  assign instr_count = instr_count_q;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: a per-cycle vector table plus
// hand-written sequences for memory waits, latency and reset abort.
module tb_multicycle_control_fsm;

  typedef struct packed {
    logic [2:0] state;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       ir_we;
    logic       mem_addr_sel;
    logic       mem_re;
    logic       mem_we;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] wb_sel;
    logic       alu_src_b;
    logic [2:0] alu_op;
    logic       illegal;
    logic       instr_done;
  } out_t;

  typedef struct {
    string      name;
    logic       rst;
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    logic       rdy;
    out_t       exp;
  } vec_t;

  localparam logic [5:0] LW = 6'h23, SW = 6'h2B, BNE = 6'h05, ADDI = 6'h08;
  localparam logic [5:0] XORI = 6'h0E, J = 6'h02, JAL = 6'h03, RT = 6'h00;
  localparam logic [5:0] BAD = 6'h3F;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  out_t cur;
  vec_t vecs[$];

  multicycle_control_fsm_if #(.OP_W(6), .FUNCT_W(6), .ALU_OP_W(3)) bus ();

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cycle_count, instr_count;
  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .ctrl(bus),
    .cycle_count(cycle_count), .instr_count(instr_count)
  );
`else
  multicycle_control_fsm dut (.clk(clk), .reset(reset), .ctrl(bus));
`endif

  always #5 clk = ~clk;

  function automatic out_t e(input logic [2:0] st, input logic pcwe, input logic [1:0] pcs,
                             input logic irwe, input logic mas, input logic mre,
                             input logic mwe, input logic rwe, input logic [1:0] rd,
                             input logic [1:0] wb, input logic asb, input logic [2:0] aop,
                             input logic ill, input logic done);
    return '{st, pcwe, pcs, irwe, mas, mre, mwe, rwe, rd, wb, asb, aop, ill, done};
  endfunction

  function automatic out_t get_out();
    return '{bus.state, bus.pc_we, bus.pc_src, bus.ir_we, bus.mem_addr_sel, bus.mem_re,
             bus.mem_we, bus.reg_we, bus.reg_dst, bus.wb_sel, bus.alu_src_b, bus.alu_op,
             bus.illegal, bus.instr_done};
  endfunction

  task automatic add(input string nm, input logic r, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic rdy, input out_t ex);
    vec_t v;
    v.name = nm; v.rst = r; v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.exp = ex;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, sample outputs mid-cycle, then cross the edge.
  task automatic step(input logic r, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic rdy);
    reset         = r;
    bus.opcode    = op;
    bus.funct     = fn;
    bus.zero_flag = z;
    bus.mem_ready = rdy;
    #4;
    cur = get_out();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_o(input string nm, input out_t got, input out_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  initial begin
    out_t z0, f1, f0, d0;
    int   cycles, regwe_at, mwe_cnt, mas_cnt, rwe_cnt, st_bad;
    bit   done_seen;

    z0 = e(0,0,0,0,0,0,0,0,0,0,0,0,0,0);
    f1 = e(0,1,0,1,0,1,0,0,0,0,0,0,0,0);
    f0 = e(0,0,0,0,0,1,0,0,0,0,0,0,0,0);
    d0 = e(1,0,0,0,0,0,0,0,0,0,0,0,0,0);

    add("rst",    1, LW,   6'h00, 0, 1, z0);
    add("lw_f",   0, LW,   6'h00, 0, 1, f1);
    add("lw_d",   0, LW,   6'h00, 0, 1, d0);
    add("lw_x",   0, LW,   6'h00, 0, 1, e(2,0,0,0,0,0,0,0,0,0,1,0,0,0));
    add("lw_m",   0, LW,   6'h00, 0, 1, e(3,0,0,0,1,1,0,0,0,0,1,0,0,0));
    add("lw_w",   0, LW,   6'h00, 0, 1, e(4,0,0,0,0,0,0,1,0,1,1,0,0,1));
    add("ad_f0",  0, ADDI, 6'h00, 0, 0, f0);
    add("ad_f1",  0, ADDI, 6'h00, 0, 1, f1);
    add("ad_d",   0, ADDI, 6'h00, 0, 1, d0);
    add("ad_x",   0, ADDI, 6'h00, 0, 1, e(2,0,0,0,0,0,0,0,0,0,1,0,0,0));
    add("ad_w",   0, ADDI, 6'h00, 0, 1, e(4,0,0,0,0,0,0,1,0,0,1,0,0,1));
    add("xo_f",   0, XORI, 6'h00, 0, 1, f1);
    add("xo_d",   0, XORI, 6'h00, 0, 1, d0);
    add("xo_x",   0, XORI, 6'h00, 0, 1, e(2,0,0,0,0,0,0,0,0,0,1,2,0,0));
    add("xo_w",   0, XORI, 6'h00, 0, 1, e(4,0,0,0,0,0,0,1,0,0,1,2,0,1));
    add("sub_f",  0, RT,   6'h22, 0, 1, f1);
    add("sub_d",  0, RT,   6'h22, 0, 0, d0);
    add("sub_x",  0, RT,   6'h22, 0, 0, e(2,0,0,0,0,0,0,0,0,0,0,1,0,0));
    add("sub_w",  0, RT,   6'h22, 0, 0, e(4,0,0,0,0,0,0,1,1,0,0,1,0,1));
    add("slt_f",  0, RT,   6'h2A, 0, 1, f1);
    add("slt_d",  0, RT,   6'h2A, 0, 1, d0);
    add("slt_x",  0, RT,   6'h2A, 0, 1, e(2,0,0,0,0,0,0,0,0,0,0,3,0,0));
    add("slt_w",  0, RT,   6'h2A, 0, 1, e(4,0,0,0,0,0,0,1,1,0,0,3,0,1));
    add("add_f",  0, RT,   6'h20, 0, 1, f1);
    add("add_d",  0, RT,   6'h20, 0, 1, d0);
    add("add_x",  0, RT,   6'h20, 0, 1, e(2,0,0,0,0,0,0,0,0,0,0,0,0,0));
    add("add_w",  0, RT,   6'h20, 0, 1, e(4,0,0,0,0,0,0,1,1,0,0,0,0,1));
    add("bne0_f", 0, BNE,  6'h00, 0, 1, f1);
    add("bne0_d", 0, BNE,  6'h00, 0, 1, d0);
    add("bne0_x", 0, BNE,  6'h00, 0, 1, e(2,1,3,0,0,0,0,0,0,0,0,1,0,1));
    add("bne1_f", 0, BNE,  6'h00, 1, 1, f1);
    add("bne1_d", 0, BNE,  6'h00, 1, 1, d0);
    add("bne1_x", 0, BNE,  6'h00, 1, 1, e(2,0,3,0,0,0,0,0,0,0,0,1,0,1));
    add("ill_f",  0, BAD,  6'h00, 0, 1, f1);
    add("ill_d",  0, BAD,  6'h00, 0, 1, e(1,0,0,0,0,0,0,0,0,0,0,0,1,1));
    add("illr_f", 0, RT,   6'h3F, 0, 1, f1);
    add("illr_d", 0, RT,   6'h3F, 0, 1, e(1,0,0,0,0,0,0,0,0,0,0,0,1,1));
    add("j_f",    0, J,    6'h00, 0, 1, f1);
    add("j_d",    0, J,    6'h00, 0, 1, e(1,1,1,0,0,0,0,0,0,0,0,0,0,1));
    add("jal_f",  0, JAL,  6'h00, 0, 1, f1);
    add("jal_d",  0, JAL,  6'h00, 0, 1, e(1,1,1,0,0,0,0,1,2,2,0,0,0,1));
    add("jr_f",   0, RT,   6'h08, 0, 1, f1);
    add("jr_d",   0, RT,   6'h08, 0, 1, e(1,1,2,0,0,0,0,0,0,0,0,0,0,1));
    add("fin_f",  0, RT,   6'h00, 0, 0, f0);

    reset = 1'b1;
    bus.opcode = '0; bus.funct = '0; bus.zero_flag = 1'b0; bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].op, vecs[i].fn, vecs[i].z, vecs[i].rdy);
      chk_o(vecs[i].name, cur, vecs[i].exp);
    end

    // LW with zero-wait memory: five cycles, write-back on the last.
    cycles = 0; regwe_at = 0; done_seen = 0;
    for (int i = 0; i < 10 && !done_seen; i++) begin
      step(0, LW, 6'h00, 0, 1);
      cycles++;
      if (cur.reg_we) regwe_at = cycles;
      if (cur.instr_done) done_seen = 1;
    end
    chk("lw_latency", cycles, 5);
    chk("lw_regwe_cycle", regwe_at, 5);

    // SW with three wait cycles in MEM.
    rwe_cnt = 0; mwe_cnt = 0; mas_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step(0, SW, 6'h00, 0, 1);
      rwe_cnt += int'(cur.reg_we);
    end
    for (int i = 0; i < 4; i++) begin
      step(0, SW, 6'h00, 0, (i == 3));
      mwe_cnt += int'(cur.mem_we);
      mas_cnt += int'(cur.mem_addr_sel);
      rwe_cnt += int'(cur.reg_we);
    end
    chk("sw_mem_we_cycles", mwe_cnt, 4);
    chk("sw_addr_sel_cycles", mas_cnt, 4);
    chk("sw_reg_we", rwe_cnt, 0);
    chk("sw_done_last", int'(cur.instr_done), 1);
    step(0, SW, 6'h00, 0, 0);
    chk("sw_back_fetch", int'(cur.state), 0);

    // Reset while an SW waits in MEM aborts the store.
    step(0, SW, 6'h00, 0, 1);
    step(0, SW, 6'h00, 0, 1);
    step(0, SW, 6'h00, 0, 1);
    step(0, SW, 6'h00, 0, 0);
    chk("abort_pre_mem_we", int'(cur.mem_we), 1);
    step(1, SW, 6'h00, 0, 0);
    chk_o("abort_rst0", cur, z0);
    step(1, SW, 6'h00, 0, 0);
    chk_o("abort_rst1", cur, z0);
    mwe_cnt = 0; st_bad = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, SW, 6'h00, 0, 0);
      mwe_cnt += int'(cur.mem_we);
      if (cur.state != 3'd0) st_bad++;
    end
    chk("abort_no_mem_we", mwe_cnt, 0);
    chk("abort_stay_fetch", st_bad, 0);
    step(0, SW, 6'h00, 0, 1);
    step(0, SW, 6'h00, 0, 1);
    step(0, SW, 6'h00, 0, 1);
    step(0, SW, 6'h00, 0, 1);
    chk_o("new_sw_mem", cur, e(3,0,0,0,1,0,1,0,0,0,1,0,0,1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
